// File: rtl/alarm_mode_ctrl.sv
// Alarm clock front-panel controller: per-button debounce, press detection,
// and the CLOCK / SET_TIME / SET_ALARM / RINGING mode machine.
module alarm_mode_ctrl #(
    parameter int DB_CYCLES   = 16,
    parameter int RING_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_c,
    input  logic       btn_u,
    input  logic       btn_d,
    input  logic       btn_l,
    input  logic       btn_r,
    input  logic       alarm_match,
    output logic [1:0] mode,
    output logic       field_hr,
    output logic       inc_pulse,
    output logic       dec_pulse,
    output logic       alarm_en,
    output logic       buzzer_en
);

    localparam int DB_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int RING_W = (RING_CYCLES > 1) ? $clog2(RING_CYCLES) : 1;
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_CYCLES - 1);

    localparam int NBTN  = 5;
    localparam int IDX_C = 0;
    localparam int IDX_L = 1;
    localparam int IDX_R = 2;
    localparam int IDX_U = 3;
    localparam int IDX_D = 4;

    typedef enum logic [1:0] {
        ST_CLOCK     = 2'b00,
        ST_SET_TIME  = 2'b01,
        ST_SET_ALARM = 2'b10,
        ST_RINGING   = 2'b11
    } state_e;

    logic [NBTN-1:0] btn_raw;
    logic [NBTN-1:0] db_q, db_d;
    logic [NBTN-1:0] db_prev_q;
    logic [DB_W-1:0] cnt_q [NBTN];
    logic [DB_W-1:0] cnt_d [NBTN];
    logic [NBTN-1:0] press;

    logic ev_c, ev_l, ev_r, ev_u, ev_d, ev_any;
    logic am_s_q, am_d_q, am_rise;

    state_e            state_q;
    logic              field_hr_q;
    logic              inc_q;
    logic              dec_q;
    logic              alarm_en_q;
    logic              buzzer_q;
    logic [RING_W-1:0] ring_cnt_q;

    assign btn_raw = {btn_d, btn_u, btn_r, btn_l, btn_c};

    // A new level must persist for DB_CYCLES consecutive samples to be accepted.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < NBTN; i++) begin
            cnt_d[i] = cnt_q[i];
            if (btn_raw[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DB_LAST) begin
                db_d[i]  = btn_raw[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_q      <= '0;
            db_prev_q <= '0;
            for (int i = 0; i < NBTN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            db_q      <= db_d;
            db_prev_q <= db_q;
            for (int i = 0; i < NBTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign press = db_q & ~db_prev_q;

    // Only the highest-priority press of a cycle survives.
    assign ev_c   = press[IDX_C];
    assign ev_l   = press[IDX_L] & ~ev_c;
    assign ev_r   = press[IDX_R] & ~press[IDX_C] & ~press[IDX_L];
    assign ev_u   = press[IDX_U] & ~press[IDX_C] & ~press[IDX_L] & ~press[IDX_R];
    assign ev_d   = press[IDX_D] & ~press[IDX_C] & ~press[IDX_L] & ~press[IDX_R]
                  & ~press[IDX_U];
    assign ev_any = |press;

    // Two-stage sample so the match edge lines up one cycle after it is seen.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            am_s_q <= 1'b0;
            am_d_q <= 1'b0;
        end else begin
            am_s_q <= alarm_match;
            am_d_q <= am_s_q;
        end
    end

    assign am_rise = am_s_q & ~am_d_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_CLOCK;
            field_hr_q <= 1'b0;
            inc_q      <= 1'b0;
            dec_q      <= 1'b0;
            alarm_en_q <= 1'b0;
            buzzer_q   <= 1'b0;
            ring_cnt_q <= '0;
        end else begin
            inc_q <= 1'b0;
            dec_q <= 1'b0;
            case (state_q)
                ST_CLOCK: begin
                    if (alarm_en_q && am_rise) begin
                        state_q    <= ST_RINGING;
                        buzzer_q   <= 1'b1;
                        ring_cnt_q <= '0;
                    end else if (ev_c) begin
                        state_q    <= ST_SET_TIME;
                        field_hr_q <= 1'b1;
                    end else if (ev_u) begin
                        alarm_en_q <= ~alarm_en_q;
                    end
                end
                ST_SET_TIME, ST_SET_ALARM: begin
                    if (ev_c) begin
                        state_q    <= (state_q == ST_SET_TIME) ? ST_SET_ALARM : ST_CLOCK;
                        field_hr_q <= 1'b1;
                    end else if (ev_l) begin
                        field_hr_q <= 1'b1;
                    end else if (ev_r) begin
                        field_hr_q <= 1'b0;
                    end else if (ev_u) begin
                        inc_q <= 1'b1;
                    end else if (ev_d) begin
                        dec_q <= 1'b1;
                    end
                end
                ST_RINGING: begin
                    if (ev_any || (ring_cnt_q == RING_LAST)) begin
                        state_q  <= ST_CLOCK;
                        buzzer_q <= 1'b0;
                    end else begin
                        ring_cnt_q <= ring_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q  <= ST_CLOCK;
                    buzzer_q <= 1'b0;
                end
            endcase
        end
    end

    assign mode      = state_q;
    assign field_hr  = field_hr_q;
    assign inc_pulse = inc_q;
    assign dec_pulse = dec_q;
    assign alarm_en  = alarm_en_q;
    assign buzzer_en = buzzer_q;

endmodule
